// File: rtl/tluh_periph_reg_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tluh_periph_reg_adapter
// Purpose  : TL-UL device-side responder for one peripheral port of the
//            periph crossbar. Accepts a single A-channel request, checks it
//            against the device window and TL-UL legality rules, issues a
//            one-cycle register read or write strobe, and returns an
//            AccessAck / AccessAckData beat on the D channel. Only one
//            transaction is outstanding at a time.
//
// Ports    : clk_i, rst_i        clock, synchronous active-high reset
//            a_*                 TL-UL A channel (request in)
//            d_*                 TL-UL D channel (response out)
//            reg_we_o/reg_re_o   single-cycle write/read strobes
//            reg_addr_o          register offset (a_address & ADDR_MASK)
//            reg_wdata_o/be_o    write data and byte enables
//            reg_rdata_i/error_i device read data and error, sampled once
//            reg_ready_i         device ready (TLUH_REG_ADAPTER_WAIT_EN only)
//
// Options  : define TLUH_REG_ADAPTER_WAIT_EN to add reg_ready_i and a WAIT
//            state that stretches the access until the device is ready.
//
// Revision : 1.0 - initial release
// ============================================================================
module tluh_periph_reg_adapter #(
    parameter logic [31:0] ADDR_BASE = 32'h4000_2000,
    parameter logic [31:0] ADDR_MASK = 32'h0000_00FF,
    parameter int          AW        = 8,
    parameter int          SIW       = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,

    input  logic           a_valid_i,
    output logic           a_ready_o,
    input  logic [2:0]     a_opcode_i,
    input  logic [1:0]     a_size_i,
    input  logic [SIW-1:0] a_source_i,
    input  logic [31:0]    a_address_i,
    input  logic [3:0]     a_mask_i,
    input  logic [31:0]    a_data_i,

    output logic           d_valid_o,
    input  logic           d_ready_i,
    output logic [2:0]     d_opcode_o,
    output logic [1:0]     d_size_o,
    output logic [SIW-1:0] d_source_o,
    output logic [31:0]    d_data_o,
    output logic           d_error_o,

    output logic           reg_we_o,
    output logic           reg_re_o,
    output logic [AW-1:0]  reg_addr_o,
    output logic [31:0]    reg_wdata_o,
    output logic [3:0]     reg_be_o,
    input  logic [31:0]    reg_rdata_i,
`ifdef TLUH_REG_ADAPTER_WAIT_EN
    input  logic           reg_ready_i,
`endif
    input  logic           reg_error_i
);

    localparam logic [2:0] c_OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] c_OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] c_OP_GET         = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RSP    = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    // Captured request; held unchanged from IDLE exit until the D beat retires.
    logic [2:0]     r_opcode;
    logic [1:0]     r_size;
    logic [SIW-1:0] r_source;
    logic [31:0]    r_addr;
    logic [3:0]     r_mask;
    logic [31:0]    r_wdata;

    // Device response, sampled once per transaction.
    logic [31:0]    r_rdata;
    logic           r_rerr;

    logic           w_is_get;
    logic           w_is_put;
    logic           w_op_bad;
    logic           w_size_bad;
    logic           w_win_bad;
    logic           w_misalign;
    logic [3:0]     w_full_lanes;
    logic           w_mask_bad;
    logic           w_err;
    logic           w_sample;

    // ------------------------------------------------------------------
    // Decode of the captured request. Because the request registers are
    // stable until the response retires, the error flag is valid in
    // ACCESS, WAIT and RSP without needing its own register.
    // ------------------------------------------------------------------
    always_comb begin
        w_is_get   = (r_opcode == c_OP_GET);
        w_is_put   = (r_opcode == c_OP_PUT_FULL) || (r_opcode == c_OP_PUT_PARTIAL);
        w_op_bad   = !(w_is_get || w_is_put);
        w_size_bad = (r_size == 2'd3);
        w_win_bad  = ((r_addr & ~ADDR_MASK) != ADDR_BASE);

        w_misalign   = 1'b0;
        w_full_lanes = 4'hF;
        case (r_size)
            2'd0: begin
                w_misalign   = 1'b0;
                w_full_lanes = 4'b0001 << r_addr[1:0];
            end
            2'd1: begin
                w_misalign   = r_addr[0];
                w_full_lanes = 4'b0011 << {r_addr[1], 1'b0};
            end
            default: begin
                w_misalign   = |r_addr[1:0];
                w_full_lanes = 4'hF;
            end
        endcase

        // Only PutFullData must cover every lane of its size; partial writes
        // and reads may use any mask.
        w_mask_bad = (r_opcode == c_OP_PUT_FULL) && (r_mask != w_full_lanes);
        w_err      = w_op_bad | w_size_bad | w_win_bad | w_misalign | w_mask_bad;
    end

    // ------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (a_valid_i) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
`ifdef TLUH_REG_ADAPTER_WAIT_EN
                // A rejected request never touches the device, so it skips WAIT.
                w_state_nxt = w_err ? S_RSP : S_WAIT;
`else
                w_sample    = 1'b1;
                w_state_nxt = S_RSP;
`endif
            end
            S_WAIT: begin
`ifdef TLUH_REG_ADAPTER_WAIT_EN
                if (reg_ready_i) begin
                    w_sample    = 1'b1;
                    w_state_nxt = S_RSP;
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            S_RSP: begin
                if (d_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        a_ready_o = (r_state == S_IDLE);

        reg_we_o    = (r_state == S_ACCESS) && !w_err && w_is_put;
        reg_re_o    = (r_state == S_ACCESS) && !w_err && w_is_get;
        reg_addr_o  = AW'(r_addr & ADDR_MASK);
        reg_wdata_o = r_wdata;
        reg_be_o    = r_mask;

        // D fields are forced to zero outside RSP so idle outputs stay quiet.
        d_valid_o  = 1'b0;
        d_opcode_o = 3'd0;
        d_size_o   = 2'd0;
        d_source_o = '0;
        d_data_o   = 32'd0;
        d_error_o  = 1'b0;
        if (r_state == S_RSP) begin
            d_valid_o  = 1'b1;
            // Anything that is not a Put is answered as a Get, including
            // illegal opcodes.
            d_opcode_o = w_is_put ? 3'd0 : 3'd1;
            d_size_o   = r_size;
            d_source_o = r_source;
            d_error_o  = w_err | r_rerr;
            d_data_o   = (w_is_get && !w_err && !r_rerr) ? r_rdata : 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_opcode <= 3'd0;
            r_size   <= 2'd0;
            r_source <= '0;
            r_addr   <= 32'd0;
            r_mask   <= 4'd0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_rerr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if ((r_state == S_IDLE) && a_valid_i) begin
                r_opcode <= a_opcode_i;
                r_size   <= a_size_i;
                r_source <= a_source_i;
                r_addr   <= a_address_i;
                r_mask   <= a_mask_i;
                r_wdata  <= a_data_i;
            end

`ifdef TLUH_REG_ADAPTER_WAIT_EN
            // Clear stale device status so an error path that bypasses WAIT
            // never reports the previous transaction's data.
            if (r_state == S_ACCESS) begin
                r_rdata <= 32'd0;
                r_rerr  <= 1'b0;
            end
`endif
            if (w_sample) begin
                r_rdata <= reg_rdata_i;
                r_rerr  <= reg_error_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tluh_periph_reg_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tluh_periph_reg_adapter
// Purpose  : Directed self-checking bench for tluh_periph_reg_adapter.
//            Expected D beats are queued when a request is driven and
//            compared when the response appears; strobes, latency, stall
//            stability and reset recovery are checked along the way.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tluh_periph_reg_adapter;

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;
    logic        reg_we;
    logic        reg_re;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata;
    logic        reg_error;
    logic        reg_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [7:0]  src;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t sb[$];

    tluh_periph_reg_adapter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .a_valid_i   (a_valid),
        .a_ready_o   (a_ready),
        .a_opcode_i  (a_opcode),
        .a_size_i    (a_size),
        .a_source_i  (a_source),
        .a_address_i (a_address),
        .a_mask_i    (a_mask),
        .a_data_i    (a_data),
        .d_valid_o   (d_valid),
        .d_ready_i   (d_ready),
        .d_opcode_o  (d_opcode),
        .d_size_o    (d_size),
        .d_source_o  (d_source),
        .d_data_o    (d_data),
        .d_error_o   (d_error),
        .reg_we_o    (reg_we),
        .reg_re_o    (reg_re),
        .reg_addr_o  (reg_addr),
        .reg_wdata_o (reg_wdata),
        .reg_be_o    (reg_be),
        .reg_rdata_i (reg_rdata),
`ifdef TLUH_REG_ADAPTER_WAIT_EN
        .reg_ready_i (reg_ready),
`endif
        .reg_error_i (reg_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input rsp_t e);
        chk({tag, ".d_opcode"}, 32'(d_opcode), 32'(e.op));
        chk({tag, ".d_size"},   32'(d_size),   32'(e.size));
        chk({tag, ".d_source"}, 32'(d_source), 32'(e.src));
        chk({tag, ".d_data"},   d_data,        e.data);
        chk({tag, ".d_error"},  32'(d_error),  32'(e.err));
    endtask

    task automatic wait_a_ready(input string tag);
        int n = 0;
        while (a_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (a_ready !== 1'b1) chk({tag, ".a_ready_timeout"}, 32'(a_ready), 32'd1);
    endtask

    // strobe: 0 = none, 1 = write, 2 = read. hold = RSP cycles with d_ready low.
    task automatic run_txn(input string tag,
                           input logic [2:0] op, input logic [1:0] sz,
                           input logic [7:0] src, input logic [31:0] addr,
                           input logic [3:0] mask, input logic [31:0] wdata,
                           input logic [31:0] rdata, input logic rerr,
                           input int strobe, input logic [7:0] eaddr,
                           input logic [2:0] eop, input logic [31:0] edata,
                           input logic eerr, input int hold);
        rsp_t e;
        wait_a_ready(tag);
        a_valid   = 1'b1;
        a_opcode  = op;
        a_size    = sz;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = wdata;
        reg_rdata = rdata;
        reg_error = rerr;
        d_ready   = (hold == 0);
        e.op = eop; e.size = sz; e.src = src; e.data = edata; e.err = eerr;
        sb.push_back(e);

        @(posedge clk); #1;               // ACCESS cycle (N+1)
        a_valid = 1'b0;
        chk({tag, ".acc_a_ready"}, 32'(a_ready), 32'd0);
        chk({tag, ".acc_d_valid"}, 32'(d_valid), 32'd0);
        chk({tag, ".acc_we"}, 32'(reg_we), (strobe == 1) ? 32'd1 : 32'd0);
        chk({tag, ".acc_re"}, 32'(reg_re), (strobe == 2) ? 32'd1 : 32'd0);
        if (strobe != 0) chk({tag, ".acc_addr"}, 32'(reg_addr), 32'(eaddr));
        if (strobe == 1) begin
            chk({tag, ".acc_wdata"}, reg_wdata, wdata);
            chk({tag, ".acc_be"}, 32'(reg_be), 32'(mask));
        end

        @(posedge clk); #1;               // first RSP cycle (N+2)
        reg_rdata = 32'hBAD0_BAD0;        // must already have been sampled
        reg_error = 1'b0;
        chk({tag, ".rsp_d_valid"}, 32'(d_valid), 32'd1);
        chk({tag, ".rsp_no_strobe"}, {30'd0, reg_we, reg_re}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            chk({tag, ".stall_a_ready"}, 32'(a_ready), 32'd0);
            chk({tag, ".stall_d_valid"}, 32'(d_valid), 32'd1);
            if (sb.size() > 0) chk_d({tag, ".stall"}, sb[0]);
            @(posedge clk); #1;
        end
        d_ready = 1'b1;
        if (sb.size() == 0) chk({tag, ".sb_underflow"}, 32'd0, 32'd1);
        else begin
            e = sb.pop_front();
            chk_d(tag, e);
        end
        @(posedge clk); #1;
        chk({tag, ".done_d_valid"}, 32'(d_valid), 32'd0);
        chk({tag, ".done_a_ready"}, 32'(a_ready), 32'd1);
        d_ready = 1'b0;
    endtask

    // Reset asserted in ACCESS (to_rsp = 0) or in RSP (to_rsp = 1).
    task automatic reset_mid(input string tag, input bit to_rsp);
        wait_a_ready(tag);
        d_ready   = 1'b0;
        a_valid   = 1'b1;
        a_opcode  = 3'd4;
        a_size    = 2'd2;
        a_source  = 8'h5A;
        a_address = 32'h4000_2010;
        a_mask    = 4'hF;
        reg_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        a_valid = 1'b0;
        if (to_rsp) begin
            @(posedge clk); #1;
            chk({tag, ".pre_d_valid"}, 32'(d_valid), 32'd1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk({tag, ".d_valid"}, 32'(d_valid), 32'd0);
        chk({tag, ".a_ready"}, 32'(a_ready), 32'd1);
        chk({tag, ".strobe"}, {30'd0, reg_we, reg_re}, 32'd0);
        @(posedge clk); #1;
        chk({tag, ".post_d_valid"}, 32'(d_valid), 32'd0);
        chk({tag, ".post_strobe"}, {30'd0, reg_we, reg_re}, 32'd0);
        chk({tag, ".post_a_ready"}, 32'(a_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        a_valid   = 1'b0;
        a_opcode  = 3'd0;
        a_size    = 2'd0;
        a_source  = 8'd0;
        a_address = 32'd0;
        a_mask    = 4'd0;
        a_data    = 32'd0;
        d_ready   = 1'b0;
        reg_rdata = 32'd0;
        reg_error = 1'b0;
        reg_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset.a_ready", 32'(a_ready), 32'd1);
        chk("reset.d_valid", 32'(d_valid), 32'd0);
        chk("reset.strobes", {30'd0, reg_we, reg_re}, 32'd0);
        chk("reset.reg_addr", 32'(reg_addr), 32'd0);
        chk("reset.reg_be", 32'(reg_be), 32'd0);
        chk("reset.d_data", d_data, 32'd0);
        chk("reset.d_error", 32'(d_error), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        //       tag         op    sz    src    addr           mask  wdata          rdata          rerr strb eaddr  eop   edata          eerr hold
        run_txn("get_ok",    3'd4, 2'd2, 8'h11, 32'h4000_2004, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 8'h04, 3'd1, 32'hDEAD_BEEF, 1'b0, 0);
        run_txn("putfull",   3'd0, 2'd2, 8'h22, 32'h4000_2008, 4'hF, 32'h1234_5678, 32'hCAFE_F00D, 1'b0, 1, 8'h08, 3'd0, 32'h0,         1'b0, 0);
        run_txn("get_win",   3'd4, 2'd2, 8'h33, 32'h4000_3000, 4'hF, 32'h0,         32'hAAAA_5555, 1'b0, 0, 8'h00, 3'd1, 32'h0,         1'b1, 0);
        run_txn("op2",       3'd2, 2'd2, 8'h34, 32'h4000_2000, 4'hF, 32'h0,         32'hAAAA_5555, 1'b0, 0, 8'h00, 3'd1, 32'h0,         1'b1, 0);
        run_txn("pf_mask",   3'd0, 2'd2, 8'h44, 32'h4000_2000, 4'h3, 32'h0BAD_0001, 32'h0,         1'b0, 0, 8'h00, 3'd0, 32'h0,         1'b1, 0);
        run_txn("pf_align",  3'd0, 2'd2, 8'h45, 32'h4000_2002, 4'hF, 32'h0BAD_0002, 32'h0,         1'b0, 0, 8'h00, 3'd0, 32'h0,         1'b1, 0);
        run_txn("size3",     3'd4, 2'd3, 8'h46, 32'h4000_2000, 4'hF, 32'h0,         32'h7777_7777, 1'b0, 0, 8'h00, 3'd1, 32'h0,         1'b1, 0);
        run_txn("ppartial",  3'd1, 2'd2, 8'h55, 32'h4000_200C, 4'h5, 32'hA5A5_5A5A, 32'h0,         1'b0, 1, 8'h0C, 3'd0, 32'h0,         1'b0, 0);
        run_txn("pf_byte",   3'd0, 2'd0, 8'h56, 32'h4000_20F3, 4'h8, 32'hEE00_0000, 32'h0,         1'b0, 1, 8'hF3, 3'd0, 32'h0,         1'b0, 0);
        run_txn("pf_half",   3'd0, 2'd1, 8'h57, 32'h4000_2006, 4'hC, 32'hBEEF_0000, 32'h0,         1'b0, 1, 8'h06, 3'd0, 32'h0,         1'b0, 0);
        run_txn("pf_halfbe", 3'd0, 2'd1, 8'h58, 32'h4000_2006, 4'h3, 32'hBEEF_0000, 32'h0,         1'b0, 0, 8'h00, 3'd0, 32'h0,         1'b1, 0);
        run_txn("get_deverr",3'd4, 2'd2, 8'h66, 32'h4000_2020, 4'hF, 32'h0,         32'h1357_9BDF, 1'b1, 2, 8'h20, 3'd1, 32'h0,         1'b1, 0);
        run_txn("put_deverr",3'd0, 2'd2, 8'h67, 32'h4000_2024, 4'hF, 32'h0246_8ACE, 32'h0,         1'b1, 1, 8'h24, 3'd0, 32'h0,         1'b1, 0);
        run_txn("get_stall", 3'd4, 2'd2, 8'h77, 32'h4000_20FC, 4'hF, 32'h0,         32'h0F0F_F0F0, 1'b0, 2, 8'hFC, 3'd1, 32'h0F0F_F0F0, 1'b0, 5);

        reset_mid("rst_access", 1'b0);
        reset_mid("rst_rsp",    1'b1);
        run_txn("get_after_rst", 3'd4, 2'd2, 8'h88, 32'h4000_2040, 4'hF, 32'h0, 32'h2468_ACE0, 1'b0, 2, 8'h40, 3'd1, 32'h2468_ACE0, 1'b0, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
